extbus_host: RTL and testbench



---
 rtl/extbus_host.sv | 158 +++++++++++++++
 tb/tb_extbus_host.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/extbus_host.sv
// Host-side initiator for the VERA 8-bit external bus: converts valid/ready
// requests into timed cs_n/rd_n/wr_n cycles and synchronizes the device IRQ.
module extbus_host #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1,
  parameter int TURN_CYCLES   = 1
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       irq,
  output logic       extbus_cs_n,
  output logic       extbus_rd_n,
  output logic       extbus_wr_n,
  output logic [4:0] extbus_a,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  input  logic [7:0] extbus_d_in,
  input  logic       extbus_irq_n
);

  // Phase counters load N-1 on entry and leave the phase when they hit zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       wr_q;
  logic       ready_q;
  logic       cs_n_q;
  logic       rd_n_q;
  logic       wr_n_q;
  logic [4:0] a_q;
  logic [7:0] dout_q;
  logic       doe_q;
  logic       rv_q;
  logic [7:0] rdata_q;
  logic       irq_s1_q;
  logic       irq_s2_q;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a_q     <= 5'd0;
      dout_q  <= 8'd0;
      doe_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b0;
            a_q     <= req_addr;
            wr_q    <= req_write;
            if (req_write) begin
              dout_q <= req_wdata;
              doe_q  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= STROBE;
            cnt_q   <= STROBE_LD;
            rd_n_q  <= wr_q;
            wr_n_q  <= ~wr_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            // Read data is captured on the same edge that releases rd_n.
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rv_q    <= 1'b1;
            if (!wr_q) rdata_q <= extbus_d_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= TURN;
            cnt_q   <= TURN_LD;
            cs_n_q  <= 1'b1;
            doe_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        TURN: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cs_n_q  <= 1'b1;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          doe_q   <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchronizer; flops idle at the deasserted (high) level.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
    end else begin
      irq_s1_q <= extbus_irq_n;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rv_q;
  assign rsp_rdata    = rdata_q;
  assign irq          = ~irq_s2_q;
  assign extbus_cs_n  = cs_n_q;
  assign extbus_rd_n  = rd_n_q;
  assign extbus_wr_n  = wr_n_q;
  assign extbus_a     = a_q;
  assign extbus_d_out = dout_q;
  assign extbus_d_oe  = doe_q;

endmodule

// File: tb/tb_extbus_host.sv
// Bench for extbus_host: default-timing and S2/T5/H2/U3 instances share stimulus,
// a phase-based model predicts every output each cycle, plus literal checks.
module tb_extbus_host;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic       rst_n;
  logic       req_valid, req_write, irq_n;
  logic [4:0] req_addr;
  logic [7:0] req_wdata, d_in;

  wire [1:0]      ready, cs_n, rd_n, wr_n, doe, rv, irq;
  wire [1:0][4:0] a;
  wire [1:0][7:0] dout, rdata;

  extbus_host u_a (
    .clk25(clk25), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .irq(irq[0]),
    .extbus_cs_n(cs_n[0]), .extbus_rd_n(rd_n[0]), .extbus_wr_n(wr_n[0]),
    .extbus_a(a[0]), .extbus_d_out(dout[0]), .extbus_d_oe(doe[0]),
    .extbus_d_in(d_in), .extbus_irq_n(irq_n)
  );

  extbus_host #(.SETUP_CYCLES(2), .STROBE_CYCLES(5), .HOLD_CYCLES(2), .TURN_CYCLES(3)) u_b (
    .clk25(clk25), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .irq(irq[1]),
    .extbus_cs_n(cs_n[1]), .extbus_rd_n(rd_n[1]), .extbus_wr_n(wr_n[1]),
    .extbus_a(a[1]), .extbus_d_out(dout[1]), .extbus_d_oe(doe[1]),
    .extbus_d_in(d_in), .extbus_irq_n(irq_n)
  );

  localparam int PS [2] = '{1, 2};
  localparam int PT [2] = '{3, 5};
  localparam int PH [2] = '{1, 2};
  localparam int PU [2] = '{1, 3};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: j counts edges since the handshake; outputs follow from j directly.
  bit         m_busy [2];
  int         m_j    [2];
  bit         m_wr   [2];
  logic [4:0] m_a    [2];
  logic [7:0] m_wd   [2];
  logic [7:0] m_rd   [2];
  logic       ih_old, ih_new;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_j[i] <= 0; m_wr[i] <= 1'b0;
        m_a[i] <= 5'd0; m_wd[i] <= 8'd0; m_rd[i] <= 8'd0;
      end
      ih_old <= 1'b1;
      ih_new <= 1'b1;
    end else begin
      ih_old <= ih_new;
      ih_new <= irq_n;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (!m_wr[i] && m_j[i] == PS[i] + PT[i] - 1) m_rd[i] <= d_in;
          m_j[i] <= m_j[i] + 1;
          if (m_j[i] + 1 == PS[i] + PT[i] + PH[i] + PU[i]) m_busy[i] <= 1'b0;
        end else if (req_valid) begin
          m_busy[i] <= 1'b1; m_j[i] <= 0; m_wr[i] <= req_write;
          m_a[i] <= req_addr; m_wd[i] <= req_wdata;
        end
      end
    end
  end

  function automatic logic [27:0] pack(input logic r, cs, rd, wr, oe, v, iq,
                                       input logic [4:0] ad, input logic [7:0] d, rdat);
    return {r, cs, rd, wr, oe, v, iq, ad, (oe ? d : 8'h00), rdat};
  endfunction

  always @(negedge clk25) begin
    for (int i = 0; i < 2; i++) begin
      automatic int  j   = m_j[i];
      automatic bit  b   = m_busy[i];
      automatic bit  act = b && j < PS[i] + PT[i] + PH[i];
      automatic bit  stb = b && j >= PS[i] && j < PS[i] + PT[i];
      automatic logic [27:0] e, g;
      e = pack(!b, !act, !(stb && !m_wr[i]), !(stb && m_wr[i]), act && m_wr[i],
               b && j == PS[i] + PT[i], ~ih_old, m_a[i], m_wd[i], m_rd[i]);
      g = pack(ready[i], cs_n[i], rd_n[i], wr_n[i], doe[i], rv[i], irq[i],
               a[i], dout[i], rdata[i]);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle%0d inst%0d outputs: got %h expected %h", cyc, i, g, e);
      end
    end
  end

  // Event monitors feeding the literal checks.
  int run [2], last_len [2], rv_cnt [2], rv_cyc [2], rdlow_cnt [2], oe_cnt [2], cslow_cnt [2];
  logic [7:0] rd_at_rv [2];
  int hs_a [$], hs_b [$];

  always @(negedge clk25) begin
    for (int i = 0; i < 2; i++) begin
      if (!rd_n[i] || !wr_n[i]) run[i]++;
      else if (run[i] != 0) begin last_len[i] = run[i]; run[i] = 0; end
      if (rv[i]) begin rv_cnt[i]++; rv_cyc[i] = cyc; rd_at_rv[i] = rdata[i]; end
      if (!rd_n[i]) rdlow_cnt[i]++;
      if (doe[i]) oe_cnt[i]++;
      if (!cs_n[i]) cslow_cnt[i]++;
      if (ready[i] && req_valid && rst_n) begin
        if (i == 0) hs_a.push_back(cyc + 1); else hs_b.push_back(cyc + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #2;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      rv_cnt[i] = 0; rdlow_cnt[i] = 0; oe_cnt[i] = 0; cslow_cnt[i] = 0; last_len[i] = 0;
    end
    hs_a.delete(); hs_b.delete();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0;
    req_wdata = 8'd0; d_in = 8'd0; irq_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = 5'($urandom);
      req_wdata = 8'($urandom); d_in = 8'($urandom); irq_n = 1'($urandom);
      tick(1);
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_values_inst%0d", i),
          32'({ready[i], cs_n[i], rd_n[i], wr_n[i], a[i], dout[i], doe[i], rv[i], rdata[i], irq[i]}),
          32'({4'b1111, 5'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}));
    req_valid = 1'b0; irq_n = 1'b1; d_in = 8'h00; rst_n = 1'b1;
    tick(2);

    // Write 0x5A to 0x03
    clr();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h03; req_wdata = 8'h5A;
    tick(1);
    req_valid = 1'b0;
    tick(14);
    chk("wr_strobe_len_a", 32'(last_len[0]), 32'd3);
    chk("wr_strobe_len_b", 32'(last_len[1]), 32'd5);
    chk("wr_rsp_pulses_a", 32'(rv_cnt[0]), 32'd1);
    chk("wr_rd_low_a", 32'(rdlow_cnt[0]), 32'd0);
    chk("wr_cs_low_a", 32'(cslow_cnt[0]), 32'd5);
    chk("wr_oe_cycles_a", 32'(oe_cnt[0]), 32'd5);
    chk("wr_rdata_kept_a", 32'(rdata[0]), 32'h00);

    // Read 0x1F; bus data valid only around A's strobe
    clr();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h1F; req_wdata = 8'hEE; d_in = 8'hA5;
    tick(1);
    req_valid = 1'b0;
    tick(4);
    d_in = 8'h00;
    tick(10);
    chk("rd_data_at_rsp_a", 32'(rd_at_rv[0]), 32'hA5);
    chk("rd_rsp_phase_a", 32'(rv_cyc[0] - hs_a[0]), 32'd4);
    chk("rd_rsp_phase_b", 32'(rv_cyc[1] - hs_b[0]), 32'd7);
    chk("rd_oe_never_a", 32'(oe_cnt[0]), 32'd0);
    chk("rd_rdata_held_a", 32'(rdata[0]), 32'hA5);
    chk("rd_rdata_b", 32'(rdata[1]), 32'h00);

    // Back-to-back with req_valid held
    clr();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h0A; req_wdata = 8'hC3;
    tick(1);
    req_write = 1'b0; req_addr = 5'h15; d_in = 8'h3E;
    tick(29);
    req_valid = 1'b0;
    tick(14);
    chk("b2b_count_a", 32'(hs_a.size()), 32'd5);
    chk("b2b_count_b", 32'(hs_b.size()), 32'd3);
    for (int k = 1; k < hs_a.size(); k++)
      chk($sformatf("b2b_gap_a%0d", k), 32'(hs_a[k] - hs_a[k-1]), 32'd7);
    for (int k = 1; k < hs_b.size(); k++)
      chk($sformatf("b2b_gap_b%0d", k), 32'(hs_b[k] - hs_b[k-1]), 32'd13);

    // Reset during A's second strobe cycle
    clr();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h11; req_wdata = 8'h3C;
    tick(1);
    req_valid = 1'b0;
    tick(2);
    chk("mid_pre_wr_low_a", 32'(wr_n[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_release_a", 32'({wr_n[0], rd_n[0], cs_n[0], doe[0]}), 32'b1110);
    chk("mid_release_b", 32'({wr_n[1], rd_n[1], cs_n[1], doe[1]}), 32'b1110);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("mid_no_rsp_a", 32'(rv_cnt[0]), 32'd0);
    chk("mid_no_rsp_b", 32'(rv_cnt[1]), 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h07; d_in = 8'h96;
    tick(1);
    req_valid = 1'b0;
    tick(14);
    chk("post_rst_rsp_a", 32'(rv_cnt[0]), 32'd1);
    chk("post_rst_rsp_b", 32'(rv_cnt[1]), 32'd1);
    chk("post_rst_rdata_a", 32'(rdata[0]), 32'h96);
    chk("post_rst_rdata_b", 32'(rdata[1]), 32'h96);

    // Interrupt synchronizer latency
    irq_n = 1'b0;
    tick(1); chk("irq_assert_edge1", 32'(irq), 32'b00);
    tick(1); chk("irq_assert_edge2", 32'(irq), 32'b11);
    irq_n = 1'b1;
    tick(1); chk("irq_release_edge1", 32'(irq), 32'b11);
    tick(1); chk("irq_release_edge2", 32'(irq), 32'b00);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
